conv_loop_sequencer: RTL and testbench

CONV_LOOP_SEQUENCER -- requirements
Module: conv_loop_sequencer

---
 rtl/conv_pkg.sv | 25 ++
 rtl/conv_delay_line.sv | 27 ++
 rtl/conv_loop_sequencer.sv | 171 +++++++++++++++++
 tb/tb_conv_loop_sequencer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared layer constants, FSM state encodings and the delay-line payload for
// the convolution loop sequencer.
package conv_pkg;

    localparam int K_DEF        = 5;
    localparam int IN_SIZE_DEF  = 32;
    localparam int OUT_SIZE_DEF = 28;
    localparam int IN_CH_DEF    = 1;
    localparam int OUT_CH_DEF   = 6;
    localparam int RD_LAT_DEF   = 2;
    localparam int ADDR_W       = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef struct packed {
        logic              valid;
        logic              first;
        logic              last_tap;
        logic [ADDR_W-1:0] out_addr;
    } dl_word_t;

endpackage

// File: rtl/conv_delay_line.sv
// Enable-gated shift register that aligns per-tuple control with the buffer
// read data; dout is din delayed by DEPTH enabled cycles.
module conv_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] taps [DEPTH];

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
        end else if (en) begin
            taps[0] <= din;
            for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
        end
    end

    assign dout = taps[DEPTH-1];

endmodule

// File: rtl/conv_loop_sequencer.sv
// Address and accumulate/write sequencer for one convolution layer.
// Optional stall input is built only when CONV_STALL_EN is defined.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start; counters at tuple 0
// ST_RUN   | one read tuple issued per cycle (rd_en high)
// ST_DRAIN | no new reads; waiting for last product and output write
// ST_DONE  | one-cycle done pulse, then back to idle
module conv_loop_sequencer
    import conv_pkg::*;
#(
    parameter int K        = K_DEF,
    parameter int IN_SIZE  = IN_SIZE_DEF,
    parameter int OUT_SIZE = OUT_SIZE_DEF,
    parameter int IN_CH    = IN_CH_DEF,
    parameter int OUT_CH   = OUT_CH_DEF,
    parameter int RD_LAT   = RD_LAT_DEF
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        start,
`ifdef CONV_STALL_EN
    input  logic        stall,
`endif
    output logic        busy,
    output logic        done,
    output logic        rd_en,
    output logic [15:0] ifm_addr,
    output logic [15:0] weight_addr,
    output logic        acc_clr,
    output logic        acc_en,
    output logic        out_we,
    output logic [15:0] out_addr
);

    localparam int DL_DEPTH = RD_LAT + 1;
    localparam int DL_W     = $bits(dl_word_t);

    logic [1:0]  state;
    logic [7:0]  drain_cnt;
    logic [15:0] cnt_m, cnt_r, cnt_c, cnt_n, cnt_i, cnt_j;
    logic        rd_en_q, first_q, last_tap_q, last_q, out_we_q;
    logic [15:0] oaddr_q;
    logic        adv, issue;
    logic        wrap_j, wrap_i, wrap_n, wrap_c, wrap_r, wrap_m;
    logic [15:0] ifm_next, weight_next, oaddr_next;
    dl_word_t    dl_in, dl_out;

`ifdef CONV_STALL_EN
    assign adv = ~stall;
`else
    assign adv = 1'b1;
`endif

    assign wrap_j = (cnt_j == 16'(K - 1));
    assign wrap_i = (cnt_i == 16'(K - 1));
    assign wrap_n = (cnt_n == 16'(IN_CH - 1));
    assign wrap_c = (cnt_c == 16'(OUT_SIZE - 1));
    assign wrap_r = (cnt_r == 16'(OUT_SIZE - 1));
    assign wrap_m = (cnt_m == 16'(OUT_CH - 1));

    // Address math is modulo 2^16, so doing it at 16 bits gives the truncated result.
    assign ifm_next    = cnt_n * 16'(IN_SIZE * IN_SIZE) + (cnt_r + cnt_i) * 16'(IN_SIZE)
                       + cnt_c + cnt_j;
    assign weight_next = cnt_m * 16'(IN_CH * K * K) + cnt_n * 16'(K * K)
                       + cnt_i * 16'(K) + cnt_j;
    assign oaddr_next  = cnt_m * 16'(OUT_SIZE * OUT_SIZE) + cnt_r * 16'(OUT_SIZE) + cnt_c;

    assign issue = adv && (((state == ST_IDLE) && start) || ((state == ST_RUN) && !last_q));

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
        end else if (adv) begin
            case (state)
                ST_IDLE:  if (start) state <= ST_RUN;
                ST_RUN: begin
                    if (last_q) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= 8'(RD_LAT + 1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == 8'd0) state <= ST_DONE;
                    else                   drain_cnt <= drain_cnt - 8'd1;
                end
                default:  state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cnt_m <= '0; cnt_r <= '0; cnt_c <= '0;
            cnt_n <= '0; cnt_i <= '0; cnt_j <= '0;
        end else if (issue) begin
            cnt_j <= wrap_j ? 16'd0 : cnt_j + 16'd1;
            if (wrap_j) begin
                cnt_i <= wrap_i ? 16'd0 : cnt_i + 16'd1;
                if (wrap_i) begin
                    cnt_n <= wrap_n ? 16'd0 : cnt_n + 16'd1;
                    if (wrap_n) begin
                        cnt_c <= wrap_c ? 16'd0 : cnt_c + 16'd1;
                        if (wrap_c) begin
                            cnt_r <= wrap_r ? 16'd0 : cnt_r + 16'd1;
                            if (wrap_r) cnt_m <= wrap_m ? 16'd0 : cnt_m + 16'd1;
                        end
                    end
                end
            end
        end
    end

    // Addresses and tuple tags hold their last value whenever no tuple is issued.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rd_en_q     <= 1'b0;
            last_q      <= 1'b0;
            ifm_addr    <= '0;
            weight_addr <= '0;
            first_q     <= 1'b0;
            last_tap_q  <= 1'b0;
            oaddr_q     <= '0;
        end else if (adv) begin
            rd_en_q <= issue;
            if (issue) begin
                ifm_addr    <= ifm_next;
                weight_addr <= weight_next;
                first_q     <= (cnt_n == 16'd0) && (cnt_i == 16'd0) && (cnt_j == 16'd0);
                last_tap_q  <= wrap_n && wrap_i && wrap_j;
                oaddr_q     <= oaddr_next;
                last_q      <= wrap_n && wrap_i && wrap_j && wrap_c && wrap_r && wrap_m;
            end else begin
                last_q      <= 1'b0;
            end
        end
    end

    assign dl_in = '{valid: rd_en_q, first: first_q, last_tap: last_tap_q, out_addr: oaddr_q};

    conv_delay_line #(
        .WIDTH (DL_W),
        .DEPTH (DL_DEPTH)
    ) u_delay (
        .clock (clock),
        .rst_n (rst_n),
        .en    (adv),
        .din   (dl_in),
        .dout  (dl_out)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            out_we_q <= 1'b0;
            out_addr <= '0;
        end else if (adv) begin
            out_we_q <= dl_out.valid && dl_out.last_tap;
            if (dl_out.valid && dl_out.last_tap) out_addr <= dl_out.out_addr;
        end
    end

    assign rd_en   = rd_en_q && adv;
    assign acc_en  = dl_out.valid && adv;
    assign acc_clr = dl_out.valid && dl_out.first && adv;
    assign out_we  = out_we_q && adv;
    assign busy    = (state == ST_RUN) || (state == ST_DRAIN);
    assign done    = (state == ST_DONE);

endmodule

// File: tb/tb_conv_loop_sequencer.sv
// Directed bench: a default-parameter instance for address/timing/reset checks
// and a small-layer instance for a complete layer run.
module tb_conv_loop_sequencer;

    logic        clock = 1'b0;
    logic        rst0, rst1, start0, start1, stall0, stall1;
    logic        busy0, done0, rd_en0, acc_clr0, acc_en0, out_we0;
    logic [15:0] ifm0, w0, oaddr0;
    logic        busy1, done1, rd_en1, acc_clr1, acc_en1, out_we1;
    logic [15:0] ifm1, w1, oaddr1;
    int          n_checks = 0;
    int          n_errors = 0;
    int          done0_cnt = 0;
    logic [15:0] exp_ifm [576];
    logic [15:0] exp_w   [576];

    always #5 clock = ~clock;

    conv_loop_sequencer u_dut0 (
        .clock(clock), .rst_n(rst0), .start(start0),
`ifdef CONV_STALL_EN
        .stall(stall0),
`endif
        .busy(busy0), .done(done0), .rd_en(rd_en0), .ifm_addr(ifm0), .weight_addr(w0),
        .acc_clr(acc_clr0), .acc_en(acc_en0), .out_we(out_we0), .out_addr(oaddr0)
    );

    conv_loop_sequencer #(
        .K(3), .IN_SIZE(6), .OUT_SIZE(4), .IN_CH(2), .OUT_CH(2), .RD_LAT(2)
    ) u_dut1 (
        .clock(clock), .rst_n(rst1), .start(start1),
`ifdef CONV_STALL_EN
        .stall(stall1),
`endif
        .busy(busy1), .done(done1), .rd_en(rd_en1), .ifm_addr(ifm1), .weight_addr(w1),
        .acc_clr(acc_clr1), .acc_en(acc_en1), .out_we(out_we1), .out_addr(oaddr1)
    );

    always @(negedge clock) if (done0) done0_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero0(input string tag);
        chk({tag, "_busy"},   busy0,    0);
        chk({tag, "_done"},   done0,    0);
        chk({tag, "_rd_en"},  rd_en0,   0);
        chk({tag, "_ifm"},    ifm0,     0);
        chk({tag, "_w"},      w0,       0);
        chk({tag, "_acc_en"}, acc_en0,  0);
        chk({tag, "_acc_clr"},acc_clr0, 0);
        chk({tag, "_out_we"}, out_we0,  0);
        chk({tag, "_oaddr"},  oaddr0,   0);
    endtask

    // k is the tuple index counted from the first rd_en cycle.
    task automatic run_dut0(input int last_k);
        int wait_cyc = 0;
        start0 = 1'b1;
        @(negedge clock);
        start0 = 1'b0;
        while (!rd_en0 && wait_cyc < 8) begin
            @(negedge clock);
            wait_cyc++;
        end
        chk("first_rd_en", rd_en0, 1);
        chk("t0_ifm", ifm0, 0);
        chk("t0_w",   w0,   0);
        chk("t0_busy", busy0, 1);
        for (int k = 1; k <= last_k; k++) begin
            start0 = (k == 10);
            @(negedge clock);
            case (k)
                1:  begin chk("t1_ifm", ifm0, 1); chk("t1_w", w0, 1); end
                2:  chk("t2_acc_en", acc_en0, 0);
                3:  begin chk("t3_acc_en", acc_en0, 1); chk("t3_acc_clr", acc_clr0, 1); end
                4:  begin chk("t4_acc_en", acc_en0, 1); chk("t4_acc_clr", acc_clr0, 0); end
                5:  begin chk("t5_ifm", ifm0, 32); chk("t5_w", w0, 5); end
                11: begin chk("t11_ifm", ifm0, 65); chk("t11_w", w0, 11); chk("t11_busy", busy0, 1); end
                25: begin chk("t25_ifm", ifm0, 1); chk("t25_w", w0, 0); end
                27: chk("t27_out_we", out_we0, 0);
                28: begin chk("t28_out_we", out_we0, 1); chk("t28_oaddr", oaddr0, 0); end
                19624: begin chk("m1_ifm", ifm0, 132); chk("m1_w", w0, 49); end
                default: ;
            endcase
        end
        start0 = 1'b0;
    endtask

    initial begin
        int idx = 0;
        int rd_cnt = 0, we_cnt = 0, done_cnt = 0, last_we = 0, stall_cycles = 0;
        logic finished = 1'b0;

        for (int m = 0; m < 2; m++)
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    for (int n = 0; n < 2; n++)
                        for (int i = 0; i < 3; i++)
                            for (int j = 0; j < 3; j++) begin
                                exp_ifm[idx] = 16'(n * 36 + (r + i) * 6 + (c + j));
                                exp_w[idx]   = 16'(m * 18 + n * 9 + i * 3 + j);
                                idx++;
                            end

        rst0 = 1'b0; rst1 = 1'b0;
        start0 = 1'b0; start1 = 1'b0; stall0 = 1'b0; stall1 = 1'b0;
        repeat (3) @(negedge clock);
        chk_all_zero0("reset");
        chk("reset1_busy", busy1, 0);
        rst0 = 1'b1; rst1 = 1'b1;
        @(negedge clock);

        run_dut0(500);
        rst0 = 1'b0;
        #1;
        chk_all_zero0("abort");
        @(negedge clock);
        rst0 = 1'b1;
        repeat (10) @(negedge clock);
        chk("abort_no_done", done0_cnt, 0);
        chk("abort_idle_busy", busy0, 0);
        chk("abort_idle_rd_en", rd_en0, 0);

        run_dut0(19624);
        rst0 = 1'b0;
        @(negedge clock);
        chk("dut0_no_done", done0_cnt, 0);

        start1 = 1'b1;
        @(negedge clock);
        start1 = 1'b0;
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            if (rd_en1) begin
                if (rd_cnt < 576) begin
                    chk("small_ifm", ifm1, exp_ifm[rd_cnt]);
                    chk("small_w",   w1,   exp_w[rd_cnt]);
                end
                rd_cnt++;
            end
            if (out_we1) begin
                chk("small_oaddr", oaddr1, we_cnt);
                we_cnt++;
                last_we = cyc;
            end
            if (done1) begin
                done_cnt++;
                chk("small_done_lat", cyc - last_we, 1);
                chk("small_done_busy", busy1, 0);
                finished = 1'b1;
            end
`ifdef CONV_STALL_EN
            stall1 = (rd_cnt >= 100) && (stall_cycles < 10);
            if (stall1) stall_cycles++;
`endif
            @(negedge clock);
        end
        chk("small_finished", finished, 1);
        chk("small_rd_cnt", rd_cnt, 576);
        chk("small_we_cnt", we_cnt, 32);
        chk("small_done_cnt", done_cnt, 1);
        chk("small_idle_busy", busy1, 0);
        chk("small_idle_done", done1, 0);
`ifdef CONV_STALL_EN
        chk("small_stall_cycles", stall_cycles, 10);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
